// File: rtl/rv16_mem_pkg.sv
// rv16_mem_pkg: shared widths, FSM states and requester ids for the data RAM arbiter
package rv16_mem_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG = 1'b1;
endpackage

// File: rtl/rv16_mem_arbiter_if.sv
// rv16_mem_arbiter_if: req/ready access port between one requester and the arbiter
interface rv16_mem_arbiter_if;
  import rv16_mem_pkg::*;
  logic req;
  logic we;
  logic ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  modport master(output req, we, addr, wdata, input rdata, ready);
  modport slave(input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/rv16_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker favouring the side not served last
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       id_o
);
  // a tie goes to the requester that did not win last time
  always_comb begin
    id_o = &req_i ? ~last_i : req_i[1];
    gnt_o = ~|req_i ? 2'b00 : (id_o ? 2'b10 : 2'b01);
  end
endmodule

// File: rtl/rv16_mem_arbiter.sv
// rv16_mem_arbiter: shares the single-port data RAM between the core and debug ports
module rv16_mem_arbiter
  import rv16_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  rv16_mem_arbiter_if.slave core_if,
  rv16_mem_arbiter_if.slave dbg_if,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [15:0]       busy_cnt_o
);
  state_e state_q, state_d;
  logic owner_q, owner_d, we_q, we_d, last_q, last_d;
  logic [15:0] busy_q, busy_d;
  logic [1:0] gnt;
  logic id, win, resp, waiting;
  rr_arb2 u_arb (
    .req_i ({dbg_if.req, core_if.req}),
    .last_i(last_q),
    .gnt_o (gnt),
    .id_o  (id)
  );
  // grant in IDLE drives the RAM directly; RESP returns data to the owner only
  always_comb begin
    win = state_q == IDLE && |gnt && !rst;
    resp = state_q == RESP && !rst;
    state_d = win ? RESP : IDLE;
    owner_d = win ? id : owner_q;
    last_d = win ? id : last_q;
    we_d = win ? (id ? dbg_if.we : core_if.we) : we_q;
    mem_en_o = win;
    mem_we_o = win && we_d;
    mem_addr_o = win ? (id ? dbg_if.addr : core_if.addr) : '0;
    mem_wdata_o = win ? (id ? dbg_if.wdata : core_if.wdata) : '0;
    core_if.ready = resp && owner_q == REQ_CORE;
    dbg_if.ready = resp && owner_q == REQ_DBG;
    core_if.rdata = resp && owner_q == REQ_CORE && !we_q ? mem_rdata_i : '0;
    dbg_if.rdata = resp && owner_q == REQ_DBG && !we_q ? mem_rdata_i : '0;
    waiting = state_q == IDLE ? core_if.req && dbg_if.req : (owner_q == REQ_CORE ? dbg_if.req : core_if.req);
    busy_d = waiting && busy_q != 16'hFFFF ? busy_q + 16'd1 : busy_q;
  end
  // state, ownership and wait counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= REQ_CORE;
      we_q <= 1'b0;
      last_q <= REQ_DBG;
      busy_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q <= we_d;
      last_q <= last_d;
      busy_q <= busy_d;
    end
  end
  assign busy_cnt_o = busy_q;
endmodule

// File: tb/tb_rv16_mem_arbiter.sv
// tb_rv16_mem_arbiter: scoreboard bench for the data RAM arbiter
module tb_rv16_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rv16_mem_arbiter_if core_if();
  rv16_mem_arbiter_if dbg_if();
  logic mem_en, mem_we;
  logic [9:0] mem_addr;
  logic [15:0] mem_wdata, busy_cnt;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] ram [1024];
  int tests = 0, fails = 0, dbg_pulses = 0;
  typedef struct packed {logic id; logic [15:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  rv16_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .core_if    (core_if),
    .dbg_if     (dbg_if),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .busy_cnt_o (busy_cnt)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (core_if.ready || dbg_if.ready) begin
      if (dbg_if.ready) dbg_pulses++;
      if (exp_q.size() == 0) chk("unexpected_ready", {30'd0, core_if.ready, dbg_if.ready}, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("ready_id", {30'd0, core_if.ready, dbg_if.ready}, mon_e.id ? 32'd1 : 32'd2);
        chk("rdata", mon_e.id ? dbg_if.rdata : core_if.rdata, {16'd0, mon_e.data});
        chk("other_rdata", mon_e.id ? core_if.rdata : dbg_if.rdata, 32'd0);
      end
    end
  end

  task automatic drive(input logic id, input logic r, input logic w, input logic [9:0] a, input logic [15:0] d);
    if (id) begin
      dbg_if.req = r; dbg_if.we = w; dbg_if.addr = a; dbg_if.wdata = d;
    end else begin
      core_if.req = r; core_if.we = w; core_if.addr = a; core_if.wdata = d;
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_access(input logic id, input logic w, input logic [9:0] a, input logic [15:0] d, input logic [15:0] exp);
    int n = 0;
    @(posedge clk); #1;
    drive(id, 1'b1, w, a, d);
    exp_q.push_back({id, exp});
    @(negedge clk);
    chk("grant_en", {31'd0, mem_en}, 32'd1);
    chk("grant_we", {31'd0, mem_we}, {31'd0, w});
    chk("grant_addr", {22'd0, mem_addr}, {22'd0, a});
    if (w) chk("grant_wdata", {16'd0, mem_wdata}, {16'd0, d});
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? dbg_if.ready : core_if.ready) && n < 8);
    chk("ready_latency", n, 32'd1);
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 10'h0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0;
    ram[5] = 16'hBEEF;
    drive(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 10'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
    chk("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("reset_busy", {16'd0, busy_cnt}, 32'd0);
    chk("reset_ready", {30'd0, core_if.ready, dbg_if.ready}, 32'd0);
    do_access(1'b0, 1'b0, 10'h005, 16'h0, 16'hBEEF);
    do_access(1'b1, 1'b1, 10'h010, 16'h1234, 16'h0);
    do_access(1'b0, 1'b0, 10'h010, 16'h0, 16'h1234);
    chk("dbg_pulses", dbg_pulses, 32'd1);
    do_access(1'b1, 1'b1, 10'h3FF, 16'h5A5A, 16'h0);
    do_access(1'b1, 1'b0, 10'h3FF, 16'h0, 16'h5A5A);
    @(posedge clk); #1 rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 10'h005, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 10'h010, 16'h0);
    @(negedge clk);
    chk("rst_hold_mem_en", {31'd0, mem_en}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back({1'b0, 16'hBEEF});
    exp_q.push_back({1'b1, 16'h1234});
    exp_q.push_back({1'b0, 16'hBEEF});
    exp_q.push_back({1'b1, 16'h1234});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_mem_en", {31'd0, mem_en}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk("rr_addr", {22'd0, mem_addr}, (k % 4 == 0) ? 32'h005 : 32'h010);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 10'h0, 16'h0);
    @(negedge clk);
    chk("rr_busy", {16'd0, busy_cnt}, 32'd8);
    do_reset;
    drive(1'b1, 1'b1, 1'b0, 10'h005, 16'h0);
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 16'hBEEF});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("solo_mem_en", {31'd0, mem_en}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("solo_dbg_ready", {31'd0, dbg_if.ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 10'h0, 16'h0);
    @(negedge clk);
    chk("solo_busy", {16'd0, busy_cnt}, 32'd0);
    do_reset;
    drive(1'b0, 1'b1, 1'b1, 10'h020, 16'hC0DE);
    @(negedge clk);
    chk("rstw_mem_en", {31'd0, mem_en}, 32'd1);
    chk("rstw_mem_we", {31'd0, mem_we}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
    @(negedge clk);
    chk("rstw_no_ready", {31'd0, core_if.ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    do_access(1'b0, 1'b0, 10'h020, 16'h0, 16'hC0DE);
    chk("rstw_busy", {16'd0, busy_cnt}, 32'd0);
    do_reset;
    @(negedge clk);
    force dut.busy_q = 16'hFFFE;
    @(posedge clk); #1 release dut.busy_q;
    @(negedge clk);
    chk("sat_preload", {16'd0, busy_cnt}, 32'h0000FFFE);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 10'h005, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 10'h010, 16'h0);
    exp_q.push_back({1'b0, 16'hBEEF});
    exp_q.push_back({1'b1, 16'h1234});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sat_busy", {16'd0, busy_cnt}, k == 0 ? 32'h0000FFFE : 32'h0000FFFF);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 10'h0, 16'h0);
    @(negedge clk);
    chk("sat_final", {16'd0, busy_cnt}, 32'h0000FFFF);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
